// File: rtl/aes_pkg.sv
// Shared AES controller definitions: key-length encodings, FSM states,
// round counts and the key-length to round-count helper.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128     = 2'd0,
    KL_192     = 2'd1,
    KL_256     = 2'd2,
    KL_ILLEGAL = 2'd3
  } key_len_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Number of rounds for a key length; zero for the illegal encoding.
  function automatic logic [3:0] nr_of(input key_len_t kl);
    case (kl)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / result-out handshake between the SPI assembly driver,
// the round controller and the result consumer.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] key_len;
  logic       out_valid;
  logic       out_ready;
  logic       out_err;

  // Driver/consumer side
  modport master (
    output in_valid, key_len, out_ready,
    input  in_ready, out_valid, out_err
  );

  // Controller side
  modport slave (
    input  in_valid, key_len, out_ready,
    output in_ready, out_valid, out_err
  );
endinterface

// File: rtl/aes_key_cfg_decode.sv
// Key-length decode: round count Nr, key word count Nk and illegal flag.
// Shared between the encrypt and decrypt sequencing controllers.
module aes_key_cfg_decode
  import aes_pkg::*;
(
  input  key_len_t   key_len,
  output logic [3:0] nr,
  output logic [3:0] nk,
  output logic       illegal
);

  // Pure table lookup on the key-length code
  always_comb begin
    nr      = nr_of(key_len);
    nk      = 4'd0;
    illegal = 1'b0;
    case (key_len)
      KL_128:  nk = 4'd4;
      KL_192:  nk = 4'd6;
      KL_256:  nk = 4'd8;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for a shared iterative AES-128/192/256 round
// datapath: accepts a block, steps rounds 0..Nr, then holds the result
// until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  bus,
  input  logic             abort,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [3:0]       dp_round_idx,
  output logic             dp_first,
  output logic             dp_last,
  output logic [1:0]       cfg_key_len,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  state_t           state_reg, state_next;
  logic [3:0]       round_idx_reg, round_idx_next;
  key_len_t         cfg_reg, cfg_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  key_len_t         dec_key_len;
  logic [3:0]       dec_nr;
  logic [3:0]       dec_nk;
  logic             dec_illegal;
  logic             in_ready;

  // One decoder serves both phases: in IDLE it screens the offered key
  // length for the illegal code; once a block is in flight it sees only
  // the latched configuration, so later key_len changes are harmless.
  assign dec_key_len = (state_reg == ST_IDLE) ? key_len_t'(bus.key_len) : cfg_reg;

  aes_key_cfg_decode u_decode (
    .key_len (dec_key_len),
    .nr      (dec_nr),
    .nk      (dec_nk),
    .illegal (dec_illegal)
  );

  assign in_ready      = (state_reg == ST_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.out_err   = (state_reg == ST_DONE) & err_reg;
  assign dp_load       = bus.in_valid & in_ready;
  assign busy          = (state_reg != ST_IDLE);
  assign cfg_key_len   = cfg_reg;
  assign blk_cnt       = cnt_reg;

  // State register and sequencing counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      round_idx_reg <= 4'd0;
      cfg_reg       <= KL_128;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      round_idx_reg <= round_idx_next;
      cfg_reg       <= cfg_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
    end
  end

  // Next-state logic and datapath controls decoded from the current state
  always_comb begin
    state_next     = state_reg;
    round_idx_next = round_idx_reg;
    cfg_next       = cfg_reg;
    err_next       = err_reg;
    cnt_next       = cnt_reg;
    dp_round_en    = 1'b0;
    dp_round_idx   = 4'd0;
    dp_first       = 1'b0;
    dp_last        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cfg_next       = key_len_t'(bus.key_len);
          round_idx_next = 4'd0;
          if (dec_illegal) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        dp_round_en    = 1'b1;
        dp_first       = 1'b1;
        round_idx_next = 4'd1;
        state_next     = ST_ROUND;
      end
      ST_ROUND: begin
        dp_round_en    = 1'b1;
        dp_round_idx   = round_idx_reg;
        round_idx_next = round_idx_reg + 4'd1;
        // The last middle round is Nr-1, which equals Nk+5 for every key size
        if (round_idx_reg == dec_nk + 4'd5) begin
          state_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        dp_round_en  = 1'b1;
        dp_last      = 1'b1;
        dp_round_idx = dec_nr;
        cnt_next     = cnt_reg + CNT_W'(1);
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Flush overrides everything except in IDLE; a block aborted in FINAL
    // is not counted as completed.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      err_next   = 1'b0;
      cnt_next   = cnt_reg;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a result scoreboard.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       err;
    logic [1:0] cnt;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       dp_load;
  logic       dp_round_en;
  logic [3:0] dp_round_idx;
  logic       dp_first;
  logic       dp_last;
  logic [1:0] cfg_key_len;
  logic       busy;
  logic [1:0] blk_cnt;

  int  total = 0;
  int  bad   = 0;
  int  model_cnt = 0;
  sb_t sb[$];

  aes_round_ctrl_if bus_if ();

  aes_round_ctrl #(.CNT_W(2)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus_if),
    .abort        (abort),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .dp_round_idx (dp_round_idx),
    .dp_first     (dp_first),
    .dp_last      (dp_last),
    .cfg_key_len  (cfg_key_len),
    .busy         (busy),
    .blk_cnt      (blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  bus_if.in_ready,  1);
    check({tag, "_out_valid"}, bus_if.out_valid, 0);
    check({tag, "_busy"},      busy,             0);
    check({tag, "_round_en"},  dp_round_en,      0);
  endtask

  // Offer one block, follow its rounds, then take the result after 'hold'
  // stalled cycles.
  task automatic do_block(input logic [1:0] kl, input int hold);
    sb_t        e;
    sb_t        got;
    int         cyc;
    int         k;
    int         nr;
    logic       is_err;
    is_err = (kl == 2'd3);
    nr     = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    check("accept_in_ready", bus_if.in_ready, 1);
    bus_if.in_valid = 1'b1;
    bus_if.key_len  = kl;
    #1;
    check("dp_load", dp_load, 1);
    if (!is_err) model_cnt = (model_cnt + 1) % 4;
    e.err = is_err;
    e.cnt = model_cnt[1:0];
    sb.push_back(e);
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.key_len  = kl ^ 2'b01;
    check("cfg_key_len", cfg_key_len, kl);
    cyc = 1;
    k   = 0;
    while (!bus_if.out_valid && cyc < 40) begin
      if (dp_round_en) begin
        check("round_idx", dp_round_idx, k);
        check("dp_first",  dp_first,     (k == 0));
        check("dp_last",   dp_last,      (k == nr));
        k++;
      end
      check("in_ready_busy", bus_if.in_ready, 0);
      tick();
      cyc++;
    end
    check("latency",     cyc, is_err ? 1 : nr + 2);
    check("round_count", k,   is_err ? 0 : nr + 1);
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("out_err", bus_if.out_err, got.err);
      check("blk_cnt", blk_cnt,        got.cnt);
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_round_en", dp_round_en, 0);
      tick();
      check("hold_out_valid", bus_if.out_valid, 1);
    end
    $display("block key_len=%0d latency=%0d rounds=%0d err=%0d blk_cnt=%0d",
             kl, cyc, k, bus_if.out_err, blk_cnt);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check_idle_outputs("post_handshake");
  endtask

  initial begin
    rst_n            = 1'b0;
    abort            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.key_len   = 2'd0;
    bus_if.out_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check_idle_outputs("reset");
    check("reset_out_err", bus_if.out_err, 0);
    check("reset_cfg",     cfg_key_len,    0);
    check("reset_blk_cnt", blk_cnt,        0);
    check("reset_idx",     dp_round_idx,   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // AES-128, consumer ready
    do_block(2'd0, 0);
    // AES-256, consumer stalls 5 cycles
    do_block(2'd2, 5);
    // Illegal key length
    do_block(2'd3, 0);
    check("illegal_cnt", blk_cnt, model_cnt);

    // AES-192 aborted at round 6
    bus_if.in_valid = 1'b1;
    bus_if.key_len  = 2'd1;
    tick();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dp_round_en && dp_round_idx == 4'd6) break;
      tick();
    end
    check("abort_reach_idx", dp_round_idx, 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort_round");
    check("abort_round_cnt", blk_cnt, model_cnt);
    $display("block key_len=1 aborted at round 6 blk_cnt=%0d", blk_cnt);

    // Abort together with out_ready in DONE
    bus_if.in_valid = 1'b1;
    bus_if.key_len  = 2'd0;
    tick();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus_if.out_valid) break;
      tick();
    end
    check("done_abort_valid", bus_if.out_valid, 1);
    model_cnt = (model_cnt + 1) % 4;
    check("done_abort_cnt_pre", blk_cnt, model_cnt);
    abort            = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    abort            = 1'b0;
    bus_if.out_ready = 1'b0;
    check_idle_outputs("abort_done");
    check("done_abort_cnt_post", blk_cnt, model_cnt);
    $display("block key_len=0 aborted in DONE blk_cnt=%0d", blk_cnt);

    // Asynchronous reset in the middle of round 4
    bus_if.in_valid = 1'b1;
    bus_if.key_len  = 2'd2;
    tick();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dp_round_en && dp_round_idx == 4'd4) break;
      tick();
    end
    check("rst_reach_idx", dp_round_idx, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_rst_idx",   dp_round_idx, 0);
    check("async_rst_cfg",   cfg_key_len,  0);
    check("async_rst_cnt",   blk_cnt,      0);
    check("async_rst_first", dp_first,     0);
    check("async_rst_last",  dp_last,      0);
    $display("reset asserted mid-round blk_cnt=%0d", blk_cnt);
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Counter wrap with a 2-bit counter: 1,2,3,0,1
    do_block(2'd0, 0);
    do_block(2'd1, 0);
    do_block(2'd2, 0);
    do_block(2'd0, 0);
    do_block(2'd1, 0);
    check("wrap_final_cnt", blk_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for an iterative AES-128/192/256 round datapath. It accepts one block plus key-length configuration over a valid/ready handshake, then drives the datapath's load, round-enable, round-index and first/last-round controls for Nr = 10/12/14 rounds. It presents the result with a valid/ready handshake. It sits between the SPI byte-assembly driver and a single shared round/key-schedule datapath, replacing three parallel unrolled cipher instances.

## Interface
Parameters:
- CNT_W, 16, width of the completed-block counter

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces all state to reset values immediately
- in_valid  in  1  driver offers a block; data/key already on datapath inputs
- in_ready  out  1  controller can accept; high only in IDLE
- key_len  in  2  sampled on accept: 0=128 (Nk4/Nr10), 1=192 (Nk6/Nr12), 2=256 (Nk8/Nr14), 3=illegal
- abort  in  1  synchronous flush to IDLE
- dp_load  out  1  load state and key registers; equals in_valid & in_ready
- dp_round_en  out  1  datapath executes one round this cycle
- dp_round_idx  out  4  round number 0..Nr, for key schedule/Rcon
- dp_first  out  1  round 0: AddRoundKey only
- dp_last  out  1  round Nr: skip MixColumns
- cfg_key_len  out  2  registered key_len of block in flight
- out_valid  out  1  result/err valid
- out_ready  in  1  consumer accepts result
- out_err  out  1  with out_valid: block rejected (key_len=3)
- busy  out  1  state != IDLE
- blk_cnt  out  CNT_W  completed non-error blocks, wraps

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid: latch key_len into cfg_key_len, round_idx<=0. If key_len=3 go DONE with err<=1, else INIT.
- INIT: dp_round_en=1, dp_first=1, dp_round_idx=0; round_idx<=1; go ROUND.
- ROUND: dp_round_en=1, dp_round_idx=round_idx; increment; when round_idx = Nr-1 go FINAL.
- FINAL: dp_round_en=1, dp_last=1, dp_round_idx=Nr; go DONE; blk_cnt += 1 (mod 2^CNT_W).
- DONE: out_valid=1, out_err=err; hold until out_ready, then go IDLE, clear err.
- abort (any non-IDLE state): next state IDLE, err cleared, blk_cnt unchanged; abort in IDLE ignored; abort beats out_ready in DONE.
- Nr decoded only from cfg_key_len; key_len changes after accept have no effect.
- dp_first and dp_last are never high together; dp_round_en=0 in IDLE and DONE.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_err=0, busy=0, dp_* =0, cfg_key_len=0, round_idx=0, blk_cnt=0.

## Timing
- Accept at cycle T (in_valid&in_ready). INIT at T+1, ROUND at T+2..T+Nr, FINAL at T+Nr+1, out_valid from T+Nr+2: latency 12/14/16 cycles.
- Illegal key_len: out_valid at T+1, no dp_round_en pulses.
- out_valid handshake at cycle U means in_ready=1 at U+1. No accept while DONE. Peak throughput is one block per Nr+3 cycles.
- Outputs dp_round_en/dp_first/dp_last/dp_round_idx/in_ready/out_valid are decoded from registered state only; dp_load is combinational from in_valid.
- Reset asserted mid-round: outputs at reset values without waiting for clk. The first accept is possible on the first clk edge after deassertion.

## Structure
- Shared package aes_pkg: key_len encodings (KL_128/192/256/ILLEGAL), state enum, NR_128/192/256 constants, function nr_of(key_len).
- One sub-module natural: aes_key_cfg_decode (key_len -> Nr, Nk, illegal flag), reusable by the decrypt controller.

## Test plan
- key_len=0, out_ready=1: dp_round_en high 11 cycles, idx 0..10, dp_first at idx0, dp_last at idx10, out_valid at T+12, blk_cnt=1.
- key_len=2, out_ready held 0 for 5 cycles: idx 0..14, out_valid from T+16 held stable until out_ready, then in_ready next cycle.
- key_len=3: out_valid&out_err at T+1, no round enables, blk_cnt unchanged.
- key_len=1 with abort at idx 6: IDLE next cycle, no out_valid, in_ready=1. Same-cycle abort with out_ready in DONE: IDLE, no count change.
- reset low during ROUND idx 4 (between edges): all outputs immediately at reset values. After release, a key_len=0 block completes normally.
- CNT_W=2, five legal blocks back-to-back: blk_cnt 1,2,3,0,1.
